// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-port unified memory between the
// instruction-fetch port and the load/store data port. Data wins ties
// unless fetch has been passed over MAX_DATA_BURST times in a row. A
// granted request is held on the memory bus until memAck or until it
// times out, then the owner gets a one-cycle valid pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // fetch port
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic [DATA_WIDTH-1:0] ifRdata,
  output logic                  ifValid,
  // load/store port
  input  logic                  dReq,
  input  logic                  dWe,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [DATA_WIDTH-1:0] dWdata,
  input  logic [3:0]            dBe,
  output logic [DATA_WIDTH-1:0] dRdata,
  output logic                  dValid,
  output logic                  busErr,
  // memory side
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  output logic [3:0]            memBe,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t                state_q;
  logic [SW-1:0]         starve_q;
  logic [TW-1:0]         timer_q;
  logic                  memReq_q, memWe_q, ifValid_q, dValid_q, busErr_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q, ifRdata_q, dRdata_q;
  logic [3:0]            memBe_q;

  logic                  gnt_d_d;
  logic                  timeout_d;
  logic [SW-1:0]         starve_d;

  // Byte-offset bits never reach the memory; the bus is word addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ifAddr[1:0], dAddr[1:0]};

  // Arbitration: data wins unless fetch has starved for a full burst;
  // also the starvation counter value to commit if this cycle grants.
  always_comb begin
    gnt_d_d   = dReq && !(ifReq && (starve_q == SW'(MAX_DATA_BURST)));
    timeout_d = (timer_q == TW'(TIMEOUT - 1));
    starve_d  = '0;
    if (gnt_d_d && ifReq)
      starve_d = (starve_q == SW'(MAX_DATA_BURST)) ? starve_q : starve_q + SW'(1);
  end

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      timer_q    <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memBe_q    <= '0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
      ifValid_q  <= 1'b0;
      dValid_q   <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      ifValid_q <= 1'b0;
      dValid_q  <= 1'b0;
      busErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dReq || ifReq) begin
            memReq_q <= 1'b1;
            timer_q  <= '0;
            starve_q <= starve_d;
            if (gnt_d_d) begin
              memAddr_q  <= {dAddr[ADDR_WIDTH-1:2], 2'b00};
              memWe_q    <= dWe;
              memBe_q    <= dWe ? dBe : 4'hF;
              memWdata_q <= dWdata;
              state_q    <= BUSY_D;
            end else begin
              memAddr_q <= {ifAddr[ADDR_WIDTH-1:2], 2'b00};
              memWe_q   <= 1'b0;
              memBe_q   <= 4'hF;
              state_q   <= BUSY_IF;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          // memAck has priority over a timeout landing in the same cycle.
          if (memAck) begin
            memReq_q <= 1'b0;
            if (state_q == BUSY_IF) begin
              ifRdata_q <= memRdata;
              ifValid_q <= 1'b1;
            end else begin
              if (!memWe_q) dRdata_q <= memRdata;
              dValid_q <= 1'b1;
            end
            state_q <= RESP;
          end else if (timeout_d) begin
            memReq_q <= 1'b0;
            busErr_q <= 1'b1;
            if (state_q == BUSY_IF) begin
              ifRdata_q <= '0;
              ifValid_q <= 1'b1;
            end else begin
              dRdata_q <= '0;
              dValid_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          // Valid/busErr pulse is visible during this cycle.
          timer_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign memBe    = memBe_q;
  assign ifRdata  = ifRdata_q;
  assign dRdata   = dRdata_q;
  assign ifValid  = ifValid_q;
  assign dValid   = dValid_q;
  assign busErr   = busErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 4, TO = 16;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          ifReq = 1'b0, dReq = 1'b0, dWe = 1'b0, memAck = 1'b0;
  logic [AW-1:0] ifAddr = '0, dAddr = '0;
  logic [DW-1:0] dWdata = '0, memRdata = '0;
  logic [3:0]    dBe = '0;
  logic [DW-1:0] ifRdata, dRdata, memWdata;
  logic [AW-1:0] memAddr;
  logic [3:0]    memBe;
  logic          ifValid, dValid, busErr, memReq, memWe;

  int n_tests = 0, n_fail = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifValid(ifValid),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
    .dRdata(dRdata), .dValid(dValid), .busErr(busErr),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memRdata(memRdata), .memAck(memAck));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0; ifReq = 0; dReq = 0; dWe = 0; memAck = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [2*DW+AW+DW+4+5-1:0] outs;
    reset_n = 1'b0;
    #1;
    outs = {ifRdata, dRdata, memAddr, memWdata, memBe, ifValid, dValid, busErr, memReq, memWe};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (memReq !== 1'b0 || ifValid !== 1'b0 || dValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: memReq=%b ifValid=%b dValid=%b want 0", memReq, ifValid, dValid);
    end
  endtask

  task automatic test_fetch();
    ifReq = 1; ifAddr = 32'h0000_0006;
    @(negedge clock);
    n_tests++;
    if ({memReq, memWe, memBe, memAddr} !== {1'b1, 1'b0, 4'hF, 32'h4}) begin
      n_fail++; $display("FAIL fetch_bus: req=%b we=%b be=%h addr=%h want 1 0 f 00000004", memReq, memWe, memBe, memAddr);
    end
    memAck = 1; memRdata = 32'h0010_0093;
    @(negedge clock);
    memAck = 0;
    n_tests++;
    if ({ifValid, dValid, memReq} !== 3'b100 || ifRdata !== 32'h0010_0093) begin
      n_fail++; $display("FAIL fetch_resp: ifValid=%b dValid=%b memReq=%b ifRdata=%h want 1 0 0 00100093", ifValid, dValid, memReq, ifRdata);
    end
    ifReq = 0;
    @(negedge clock);
    n_tests++;
    if (ifValid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: ifValid=%b want 0", ifValid); end
  endtask

  task automatic test_store();
    logic [DW-1:0] prev;
    int hi;
    prev = dRdata; hi = 0;
    dReq = 1; dWe = 1; dAddr = 32'h100; dWdata = 32'hCAFEBABE; dBe = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (memReq) hi++;
      if (c == 0) begin
        n_tests++;
        if ({memWe, memBe, memAddr, memWdata} !== {1'b1, 4'b0011, 32'h100, 32'hCAFEBABE}) begin
          n_fail++; $display("FAIL store_bus: we=%b be=%h addr=%h wdata=%h", memWe, memBe, memAddr, memWdata);
        end
      end
      if (c == 3) begin memAck = 1; memRdata = 32'h5555_AAAA; end
    end
    @(negedge clock);
    memAck = 0;
    n_tests++;
    if (hi != 4) begin n_fail++; $display("FAIL store_req_len: got %0d cycles want 4", hi); end
    n_tests++;
    if ({dValid, ifValid, memReq} !== 3'b100 || dRdata !== prev) begin
      n_fail++; $display("FAIL store_resp: dValid=%b ifValid=%b memReq=%b dRdata=%h want 1 0 0 %h", dValid, ifValid, memReq, dRdata, prev);
    end
    dReq = 0;
    @(negedge clock);
    n_tests++;
    if (dValid !== 1'b0) begin n_fail++; $display("FAIL store_pulse: dValid=%b want 0", dValid); end
  endtask

  task automatic test_back_to_back();
    string order;
    int both;
    order = ""; both = 0;
    do_reset();
    ifReq = 1; dReq = 1; dWe = 0; ifAddr = 32'h40; dAddr = 32'h80;
    for (int c = 0; c < 150 && order.len() < 10; c++) begin
      @(negedge clock);
      if (ifValid && dValid) both++;
      if (dValid) order = {order, "D"};
      if (ifValid) order = {order, "I"};
      memAck = memReq; memRdata = $urandom;
    end
    ifReq = 0; dReq = 0; memAck = 0;
    n_tests++;
    if (order != "DDDDIDDDDI") begin n_fail++; $display("FAIL b2b_order: got %s want DDDDIDDDDI", order); end
    n_tests++;
    if (both != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d double pulses want 0", both); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    // complete one fetch so ifRdata holds a nonzero value first
    ifReq = 1; ifAddr = 32'h200;
    @(negedge clock);
    memAck = 1; memRdata = 32'hDEAD_BEEF;
    @(negedge clock);
    memAck = 0; ifReq = 0;
    @(negedge clock);
    ifReq = 1; ifAddr = 32'h300;
    @(negedge clock);
    hi = 0;
    for (int k = 0; k < 40 && memReq; k++) begin
      hi++;
      @(negedge clock);
    end
    n_tests++;
    if (hi != TO) begin n_fail++; $display("FAIL timeout_len: memReq high %0d cycles want %0d", hi, TO); end
    n_tests++;
    if ({ifValid, busErr, dValid} !== 3'b110 || ifRdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_resp: ifValid=%b busErr=%b dValid=%b ifRdata=%h want 1 1 0 0", ifValid, busErr, dValid, ifRdata);
    end
    ifReq = 0; dReq = 1; dWe = 0; dAddr = 32'h44;
    @(negedge clock);
    n_tests++;
    if (memReq !== 1'b0 || busErr !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: memReq=%b busErr=%b want 0 0", memReq, busErr); end
    @(negedge clock);
    n_tests++;
    if (memReq !== 1'b1 || memAddr !== 32'h44) begin n_fail++; $display("FAIL timeout_next: memReq=%b addr=%h want 1 00000044", memReq, memAddr); end
    memAck = 1; memRdata = 32'h1234_5678;
    @(negedge clock);
    memAck = 0; dReq = 0;
    n_tests++;
    if ({dValid, busErr} !== 2'b10 || dRdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL timeout_recover: dValid=%b busErr=%b dRdata=%h want 1 0 12345678", dValid, busErr, dRdata);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midflight();
    logic [2*DW+AW+DW+4+5-1:0] outs;
    int bad;
    do_reset();
    dReq = 1; dWe = 0; dAddr = 32'h40;
    @(negedge clock);
    n_tests++;
    if (memReq !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: memReq=%b want 1", memReq); end
    reset_n = 0; dReq = 0;
    #1;
    outs = {ifRdata, dRdata, memAddr, memWdata, memBe, ifValid, dValid, busErr, memReq, memWe};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
    @(negedge clock);
    reset_n = 1; memAck = 1; memRdata = 32'hFFFF_0000;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      memAck = 0;
      if (ifValid || dValid || busErr || memReq) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_late_ack: got %0d active cycles want 0", bad); end
    ifReq = 1; ifAddr = 32'h23;
    @(negedge clock);
    n_tests++;
    if (memReq !== 1'b1 || memAddr !== 32'h20) begin n_fail++; $display("FAIL rstmid_next_req: memReq=%b addr=%h want 1 00000020", memReq, memAddr); end
    memAck = 1; memRdata = 32'h0BAD_F00D;
    @(negedge clock);
    memAck = 0; ifReq = 0;
    n_tests++;
    if (ifValid !== 1'b1 || ifRdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rstmid_next_resp: ifValid=%b ifRdata=%h want 1 0badf00d", ifValid, ifRdata); end
    @(negedge clock);
  endtask

  task automatic test_starve_clear();
    string order;
    int ph;
    order = ""; ph = 0;
    do_reset();
    ifReq = 1; dReq = 1; dWe = 0; ifAddr = 32'h8; dAddr = 32'hC;
    for (int c = 0; c < 200 && order.len() < 9; c++) begin
      @(negedge clock);
      if (dValid) order = {order, "D"};
      if (ifValid) order = {order, "I"};
      if (ph == 1 && memReq) begin ifReq = 1; ph = 2; end
      if (ph == 0 && order.len() == 3) begin ifReq = 0; ph = 1; end
      memAck = memReq; memRdata = $urandom;
    end
    ifReq = 0; dReq = 0; memAck = 0;
    n_tests++;
    if (order != "DDDDDDDDI") begin n_fail++; $display("FAIL starve_clear: got %s want DDDDDDDDI", order); end
    repeat (2) @(negedge clock);
  endtask

  // Randomized traffic against a transaction-level model: the model decides
  // each winner from the request lines, tracks the starvation count, and
  // predicts the bus fields, the response and the held read data.
  task automatic test_random();
    int ph, nph, cnt, dly, starve, r;
    bit own_d, eWe, eErr, ifP, dP;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata, eRd, mIf, mD;
    logic [3:0] eBe;
    ph = 0; cnt = 0; dly = 0; starve = 0; own_d = 0; eWe = 0; eErr = 0;
    ifP = 0; dP = 0; eAddr = '0; eWdata = '0; eRd = '0; mIf = '0; mD = '0; eBe = '0;
    do_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clock);
      nph = ph;
      memAck = 0; memRdata = $urandom;
      case (ph)
        0: begin
          n_tests++;
          if (memReq !== 1'b0 || ifValid !== 1'b0 || dValid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_idle cyc %0d: memReq=%b ifValid=%b dValid=%b want 0", cyc, memReq, ifValid, dValid);
          end
          memAck = ($urandom_range(0, 3) == 0);
        end
        1: begin
          n_tests++;
          if ({memReq, memWe, memBe, memAddr} !== {1'b1, eWe, eBe, eAddr} ||
              (own_d && eWe && memWdata !== eWdata) || ifValid || dValid) begin
            n_fail++; $display("FAIL rnd_bus cyc %0d: req=%b we=%b be=%h addr=%h wd=%h want 1 %b %h %h %h",
                               cyc, memReq, memWe, memBe, memAddr, memWdata, eWe, eBe, eAddr, eWdata);
          end
          cnt++;
          if (cnt - 1 == dly) begin memAck = 1; eErr = 0; eRd = memRdata; nph = 2; end
          else if (cnt == TO) begin eErr = 1; eRd = '0; nph = 2; end
        end
        default: begin
          if (own_d) begin if (eErr || !eWe) mD = eRd; end
          else mIf = eRd;
          n_tests++;
          if ({ifValid, dValid, busErr} !== {!own_d, own_d, eErr} || ifRdata !== mIf || dRdata !== mD) begin
            n_fail++; $display("FAIL rnd_resp cyc %0d: if/d/err=%b%b%b ifR=%h dR=%h want %b%b%b %h %h",
                               cyc, ifValid, dValid, busErr, ifRdata, dRdata, !own_d, own_d, eErr, mIf, mD);
          end
          if (own_d) dP = 0; else ifP = 0;
          memAck = ($urandom_range(0, 3) == 0);
          nph = 0;
        end
      endcase
      // requester fields churn every cycle; only the grant-time values count
      ifAddr = $urandom; dAddr = $urandom; dWdata = $urandom; dWe = $urandom; dBe = $urandom;
      if (!ifP && $urandom_range(0, 2) == 0) ifP = 1;
      if (!dP && $urandom_range(0, 2) == 0) dP = 1;
      ifReq = ifP; dReq = dP;
      if (ph == 0 && (ifReq || dReq)) begin
        own_d = dReq && !(ifReq && starve == MAXB);
        if (own_d) begin
          starve = ifReq ? ((starve < MAXB) ? starve + 1 : MAXB) : 0;
          eAddr = dAddr & ~32'h3; eWe = dWe; eBe = dWe ? dBe : 4'hF; eWdata = dWdata;
        end else begin
          starve = 0;
          eAddr = ifAddr & ~32'h3; eWe = 0; eBe = 4'hF;
        end
        cnt = 0;
        r = $urandom_range(0, 7);
        dly = (r == 0) ? 1000 : (r == 1) ? TO - 1 : $urandom_range(0, 3);
        nph = 1;
      end
      ph = nph;
    end
    ifReq = 0; dReq = 0; memAck = 0;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    test_starve_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
